// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and helpers for the architectural register file.
//   REG_WIDTH  : data width of each register (32)
//   REG_ADDR_W : register index width (5, fixed by the ISA)
//   NUM_REGS   : register count (32)
//   REG_ZERO   : index of the hardwired-zero register
//   write_hits : true when an enabled write targets a real register that a read port addresses
package regfile_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // r0 can never be a write target, so it can never be forwarded either.
  function automatic logic write_hits(
    input logic                  wr_en,
    input logic [REG_ADDR_W-1:0] wr_idx,
    input logic [REG_ADDR_W-1:0] rd_idx
  );
    return wr_en && (wr_idx != REG_ZERO) && (wr_idx == rd_idx);
  endfunction

endpackage

// File: rtl/regfile_reg32.sv
// regfile_reg32 -- one storage register of the register file.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low clear (dominates a pending write)
//   wr_en    in   load wr_data on the next rising edge
//   wr_data  in   WIDTH-bit load value
//   rd_data  out  current contents
module regfile_reg32
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next-state: load on write enable, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      data_d = wr_data;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flop with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data = data_q;

endmodule

// File: rtl/regfile.sv
// regfile -- 32 x 32-bit architectural register file with r0 hardwired to zero.
// Two combinational read ports (decode) and one clocked write port (writeback).
// Ports:
//   clock             in   rising-edge clock for writes
//   reset             in   asynchronous active-low; clears r1..r31 immediately
//   ctrl_writeEnable  in   write strobe
//   ctrl_writeReg     in   destination index (writes to r0 are dropped)
//   data_writeReg     in   write data
//   ctrl_readRegA/B   in   read indices
//   data_readRegA/B   out  register contents, zero-cycle latency
// Build option: define WRITE_BYPASS_EN to forward same-cycle write data to a read
// port addressing the write target (write-before-read). Undefined by default, in
// which case reads return stored contents only.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_writeEnable,
  input  logic [REG_ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]      data_writeReg,
  input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
  input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]      data_readRegA,
  output logic [WIDTH-1:0]      data_readRegB
);

  logic                wr_gate;
  logic [NUM_REGS-1:1] we_dec;
  logic [WIDTH-1:0]    reg_val [NUM_REGS];

  // Writes only happen out of reset and never to r0.
  assign wr_gate = reset && ctrl_writeEnable && (ctrl_writeReg != REG_ZERO);

  // One-hot write decoder over r1..r31.
  always_comb begin
    we_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      we_dec[i] = wr_gate && (ctrl_writeReg == REG_ADDR_W'(i));
    end
  end

  // r0 is a constant, not storage.
  assign reg_val[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
    regfile_reg32 #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk     (clock),
      .rst_n   (reset),
      .wr_en   (we_dec[g]),
      .wr_data (data_writeReg),
      .rd_data (reg_val[g])
    );
  end

`ifdef WRITE_BYPASS_EN
  logic byp_en;

  // Bypass is disabled while reset is held so reads stay at zero.
  assign byp_en = reset && ctrl_writeEnable;

  // Read muxes with write-before-read forwarding.
  always_comb begin
    data_readRegA = reg_val[ctrl_readRegA];
    data_readRegB = reg_val[ctrl_readRegB];
    if (write_hits(byp_en, ctrl_writeReg, ctrl_readRegA)) begin
      data_readRegA = data_writeReg;
    end else begin
      data_readRegA = reg_val[ctrl_readRegA];
    end
    if (write_hits(byp_en, ctrl_writeReg, ctrl_readRegB)) begin
      data_readRegB = data_writeReg;
    end else begin
      data_readRegB = reg_val[ctrl_readRegB];
    end
  end
`else
  // Read muxes returning stored contents only.
  always_comb begin
    data_readRegA = reg_val[ctrl_readRegA];
    data_readRegB = reg_val[ctrl_readRegB];
  end
`endif

endmodule
